// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT    = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    CAPTURE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port not granted last.
// Latency: combinational.
// Backpressure: none; the caller decides when a grant is actually taken.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       dm_req,
  input  owner_t     last,
  output logic [1:0] grant   // bit 0 = fetch port, bit 1 = data port
);

  // Pick the winner; on a tie the pointer hands the grant to the other port.
  always_comb begin
    grant = 2'b00;
    if (if_req && dm_req) begin
      grant = (last == OWN_DM) ? 2'b01 : 2'b10;
    end else if (if_req) begin
      grant = 2'b01;
    end else if (dm_req) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory, one transaction outstanding.
// Latency: grant at the IDLE edge, BUSY until mem_resp or timeout, resp pulses in CAPTURE; rdata updates at the end of CAPTURE.
// Backpressure: requesters hold req until resp; no new grant is made in BUSY or CAPTURE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // instruction-fetch port (read only)
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_resp,
  output logic                  if_err,
  // data port
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_resp,
  output logic                  dm_err,
  // memory side
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_t    state_q, state_d;
  owner_t        owner_q, last_q, grant_own;
  logic          we_q, grant_we;
  logic [CW-1:0] cnt_q;
  logic [1:0]    grant;
  logic          grab, finish, timed_out;

  mem_arb_rr u_rr (
    .if_req (if_req),
    .dm_req (dm_req),
    .last   (last_q),
    .grant  (grant)
  );

  assign grant_own = grant[1] ? OWN_DM : OWN_IF;
  assign grant_we  = grant[1] & dm_we;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the grab/finish strobes that the datapath blocks act on.
  always_comb begin
    state_d   = state_q;
    grab      = 1'b0;
    finish    = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          grab    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_resp) begin
          finish  = 1'b1;
          state_d = CAPTURE;
        end else if (cnt_q == CNT_LAST) begin
          finish    = 1'b1;
          timed_out = 1'b1;
          state_d   = CAPTURE;
        end
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Owner registers, round-robin pointer and BUSY cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_IF;
      last_q  <= OWN_IF;   // fetch counts as last winner so the data port takes the first tie
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else if (grab) begin
      owner_q <= grant_own;
      last_q  <= grant_own;
      we_q    <= grant_we;
      cnt_q   <= '0;
    end else if (state_q == BUSY) begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // Memory command lines: raised on grant, dropped on leaving BUSY so CAPTURE is always low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grab) begin
      mem_read  <= ~grant_we;
      mem_write <= grant_we;
      mem_addr  <= grant[1] ? dm_addr : if_addr;
      if (grant[1]) mem_wdata <= dm_wdata;
    end else if (finish) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

  // Completion pulse and timeout flag for the owner, high only during CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_resp <= 1'b0;
      if_err  <= 1'b0;
      dm_resp <= 1'b0;
      dm_err  <= 1'b0;
    end else begin
      if_resp <= finish && (owner_q == OWN_IF);
      if_err  <= finish && (owner_q == OWN_IF) && timed_out;
      dm_resp <= finish && (owner_q == OWN_DM);
      dm_err  <= finish && (owner_q == OWN_DM) && timed_out;
    end
  end

  // Read data arrives during CAPTURE (one cycle after mem_resp); writes leave rdata untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata <= '0;
      dm_rdata <= '0;
    end else if (state_q == CAPTURE && !we_q) begin
      if (owner_q == OWN_IF) if_rdata <= mem_rdata;
      else                   dm_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_resp, if_err, dm_resp, dm_err;
  logic        mem_read, mem_write;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_resp(if_resp), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_resp(dm_resp), .dm_err(dm_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  // Memory model: starts on a rising command edge, pulses mem_resp after 'delay' BUSY cycles
  // (delay 0 = never answers), and presents read data the cycle after mem_resp.
  logic [31:0] mem [0:255];
  logic [31:0] rd_hold;
  logic        act_prev;
  int          rcnt;
  int          delay;

  always @(negedge clk) begin
    if (!rst_n) begin
      rcnt     = 0;
      act_prev = 1'b0;
      mem_resp = 1'b0;
    end else begin
      if (mem_resp) mem_rdata = rd_hold;
      mem_resp = 1'b0;
      if ((mem_read || mem_write) && !act_prev) begin
        if (mem_write) mem[mem_addr[9:2]] = mem_wdata;
        rd_hold = mem[mem_addr[9:2]];
        rcnt    = delay;
      end
      if (rcnt != 0) begin
        rcnt = rcnt - 1;
        if (rcnt == 0) mem_resp = 1'b1;
      end
      act_prev = mem_read || mem_write;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until a memory command is active; bounded.
  task automatic wait_active(input string tag, output int n);
    n = 0;
    while (!(mem_read || mem_write) && n < 30) begin
      step();
      n++;
    end
    chk(tag, {31'd0, mem_read || mem_write}, 32'd1);
  endtask

  // Advance until either port pulses resp; bounded. n = cycles waited.
  task automatic wait_resp(input string tag, output int n);
    n = 0;
    while (!(if_resp || dm_resp) && n < 30) begin
      step();
      n++;
    end
    chk(tag, {31'd0, if_resp || dm_resp}, 32'd1);
  endtask

  int n, gap, busy;
  logic resp_seen;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[1]    = 32'hDEADBEEF;   // 0x004
    mem[2]    = 32'hCAFEF00D;   // 0x008
    mem[128]  = 32'h12345678;   // 0x200
    mem_rdata = 32'h0;
    mem_resp  = 1'b0;
    rcnt      = 0;
    act_prev  = 1'b0;
    rd_hold   = 32'h0;
    delay     = 2;

    // ---- reset state, both requesters already asserting ----
    rst_n    = 1'b0;
    if_req   = 1'b1;
    if_addr  = 32'h4;
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h100;
    dm_wdata = 32'h55;
    step();
    step();
    chk("rst_mem_read",  {31'd0, mem_read},  32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_addr",  mem_addr,  32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_resp",   {31'd0, if_resp},   32'd0);
    chk("rst_dm_resp",   {31'd0, dm_resp},   32'd0);
    chk("rst_if_err",    {31'd0, if_err},    32'd0);
    chk("rst_dm_err",    {31'd0, dm_err},    32'd0);
    chk("rst_if_rdata",  if_rdata,  32'd0);
    chk("rst_dm_rdata",  dm_rdata,  32'd0);

    // ---- release: tie goes to data port (write) ----
    rst_n = 1'b1;
    step();
    chk("first_grant_write", {31'd0, mem_write}, 32'd1);
    chk("first_grant_read",  {31'd0, mem_read},  32'd0);
    chk("first_grant_addr",  mem_addr,  32'h100);
    chk("first_grant_wdata", mem_wdata, 32'h55);
    wait_resp("dm_write_resp_wait", n);
    chk("dm_write_latency", n, 32'd2);
    chk("dm_write_resp",  {31'd0, dm_resp},  32'd1);
    chk("dm_write_ifresp", {31'd0, if_resp}, 32'd0);
    chk("capture_write_low", {31'd0, mem_write}, 32'd0);
    dm_req = 1'b0;
    step();
    chk("dm_resp_one_cycle", {31'd0, dm_resp}, 32'd0);
    chk("write_keeps_rdata", dm_rdata, 32'd0);
    chk("no_grant_in_capture", {31'd0, mem_read}, 32'd0);

    // ---- second grant: fetch of 0x4 ----
    step();
    chk("fetch_mem_read", {31'd0, mem_read}, 32'd1);
    chk("fetch_mem_write", {31'd0, mem_write}, 32'd0);
    chk("fetch_addr", mem_addr, 32'h4);
    step();
    chk("fetch_busy2_read", {31'd0, mem_read}, 32'd1);
    chk("fetch_busy2_addr", mem_addr, 32'h4);
    chk("fetch_busy2_noresp", {31'd0, if_resp}, 32'd0);
    step();
    chk("fetch_if_resp", {31'd0, if_resp}, 32'd1);
    chk("fetch_dm_resp", {31'd0, dm_resp}, 32'd0);
    chk("fetch_if_err",  {31'd0, if_err},  32'd0);
    if_req = 1'b0;
    step();
    chk("fetch_resp_one_cycle", {31'd0, if_resp}, 32'd0);
    chk("fetch_rdata", if_rdata, 32'hDEADBEEF);

    // ---- both held for four reads: dm, if, dm, if with a low gap ----
    dm_we   = 1'b0;
    dm_addr = 32'h200;
    if_addr = 32'h8;
    dm_req  = 1'b1;
    if_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_active("rr_active_wait", n);
      chk("rr_grant_addr", mem_addr, (k % 2 == 0) ? 32'h200 : 32'h8);
      wait_resp("rr_resp_wait", n);
      chk("rr_dm_resp", {31'd0, dm_resp}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_if_resp", {31'd0, if_resp}, (k % 2 == 0) ? 32'd0 : 32'd1);
      chk("rr_capture_low", {31'd0, mem_read || mem_write}, 32'd0);
      if (k == 3) begin
        dm_req = 1'b0;
        if_req = 1'b0;
      end else begin
        gap = 1;
        step();
        while (!(mem_read || mem_write) && gap < 30) begin
          gap++;
          step();
        end
        chk("rr_low_gap", gap, 32'd2);
      end
    end
    step();
    chk("rr_dm_rdata", dm_rdata, 32'h12345678);
    chk("rr_if_rdata", if_rdata, 32'hCAFEF00D);

    // ---- timeout: memory never answers ----
    delay   = 0;
    dm_req  = 1'b1;
    dm_addr = 32'h40;
    wait_active("tmo_active_wait", n);
    busy = 0;
    while (mem_read && busy < 40) begin
      busy++;
      step();
    end
    chk("tmo_busy_cycles", busy, 32'd8);
    chk("tmo_dm_resp",  {31'd0, dm_resp},  32'd1);
    chk("tmo_dm_err",   {31'd0, dm_err},   32'd1);
    chk("tmo_if_resp",  {31'd0, if_resp},  32'd0);
    chk("tmo_if_err",   {31'd0, if_err},   32'd0);
    chk("tmo_mem_low",  {31'd0, mem_read || mem_write}, 32'd0);
    dm_req = 1'b0;
    step();
    chk("tmo_err_pulse", {31'd0, dm_err}, 32'd0);

    // ---- reset in the middle of BUSY ----
    delay   = 4;
    if_req  = 1'b1;
    if_addr = 32'h4;
    wait_active("rstmid_active_wait", n);
    chk("rstmid_read_busy", {31'd0, mem_read}, 32'd1);
    step();
    rst_n = 1'b0;
    #1;
    chk("rstmid_read_drop", {31'd0, mem_read}, 32'd0);
    chk("rstmid_if_rdata",  if_rdata, 32'd0);
    resp_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      resp_seen = resp_seen | if_resp | dm_resp;
    end
    chk("rstmid_no_resp", {31'd0, resp_seen}, 32'd0);
    rst_n = 1'b1;
    wait_active("rstmid_refetch_wait", n);
    chk("rstmid_refetch_addr", mem_addr, 32'h4);
    wait_resp("rstmid_refetch_resp_wait", n);
    chk("rstmid_refetch_latency", n, 32'd4);
    chk("rstmid_refetch_resp", {31'd0, if_resp}, 32'd1);
    if_req = 1'b0;
    step();
    chk("rstmid_refetch_rdata", if_rdata, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32; width of every address port.
REQ-002 Parameter DATA_WIDTH, default 32; width of every data port.
REQ-003 Parameter TIMEOUT, default 64; maximum number of BUSY cycles before abort.
REQ-004 clk  in  1  sole clock; all state updates on posedge clk.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 if_req, if_addr  in  1/ADDR_WIDTH  instruction-fetch read request (level) and address.
REQ-007 if_rdata, if_resp, if_err  out  DATA_WIDTH/1/1  fetch read data, one-cycle completion pulse, timeout flag.
REQ-008 dm_req, dm_we, dm_addr, dm_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  data-port request, write-enable (1=write, 0=read), address, write data.
REQ-009 dm_rdata, dm_resp, dm_err  out  DATA_WIDTH/1/1  data-port read data, completion pulse, timeout flag.
REQ-010 mem_read, mem_write, mem_addr, mem_wdata  out  1/1/ADDR_WIDTH/DATA_WIDTH  memory command lines; memory starts an access on a 0->1 edge of mem_read or mem_write.
REQ-011 mem_rdata, mem_resp  in  DATA_WIDTH/1  memory read data and one-cycle done pulse; mem_rdata is valid the cycle after mem_resp.

Function
REQ-012 The arbiter SHALL implement states IDLE, BUSY, CAPTURE; at most one transaction is outstanding.
REQ-013 IDLE: if any req is high, latch winner, dm_we, address and wdata into owner registers, clear the timeout counter, and go to BUSY next cycle; otherwise remain in IDLE.
REQ-014 Arbitration SHALL be two-way round-robin: when both reqs are high, grant the port not granted last; a single requester always wins.
REQ-015 BUSY: drive mem_read=1 (read) or mem_write=1 (write) from registered values; mem_addr/mem_wdata come from owner registers and stay stable for the whole of BUSY.
REQ-016 BUSY->CAPTURE on mem_resp=1; the counter increments every BUSY cycle; BUSY->CAPTURE with err set when the counter equals TIMEOUT-1 and mem_resp=0.
REQ-017 CAPTURE: mem_read=mem_write=0; pulse owner's resp for exactly one cycle; owner's rdata <= mem_rdata for reads, hold previous value for writes; owner's err = timeout flag; next state IDLE.
REQ-018 The one-cycle low on mem_read/mem_write in CAPTURE guarantees a fresh rising edge for back-to-back transactions.
REQ-019 Best-case latency, req high in IDLE to resp pulse: 2 + memory response cycles; no new grant occurs in CAPTURE.
REQ-020 Requesters hold req, addr, we and wdata stable until resp; a req dropped before resp is ignored, and the transaction completes and pulses resp regardless.
REQ-021 Non-owner resp/err SHALL remain 0; rdata outputs are registered and change only in CAPTURE.

Reset
REQ-022 On rst_n=0, asynchronously: state=IDLE; mem_read, mem_write, if_resp, dm_resp, if_err, dm_err = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; counter=0; round-robin pointer = data port wins next tie.
REQ-023 Reset mid-transaction SHALL abandon it with no resp pulse; after release the arbiter accepts new requests from IDLE.

Structure
REQ-024 A shared package mem_arb_pkg SHALL hold the state enum (IDLE, BUSY, CAPTURE), the owner enum (OWN_IF, OWN_DM) and default parameter constants.
REQ-025 The round-robin grant logic SHALL be a sub-module mem_arb_rr (inputs two reqs plus pointer; outputs one-hot grant).

Verification
REQ-026 Reset: with rst_n=0, all outputs 0; release with if_req=dm_req=1 -> first grant dm (mem_write or mem_read by dm_we), second grant if.
REQ-027 Single fetch with memory DELAY=2 at word 0x00000004 = 0xDEADBEEF -> mem_read high in BUSY, one-cycle if_resp with if_rdata=0xDEADBEEF, dm_resp stays 0.
REQ-028 Both reqs held for 4 transactions -> grants alternate dm,if,dm,if; mem_read is 0 for at least one cycle between transactions.
REQ-029 Memory never responds, TIMEOUT=8 -> exactly 8 BUSY cycles, then dm_resp=1 with dm_err=1 and mem lines low.
REQ-030 Assert rst_n=0 during BUSY -> mem_read drops immediately, no resp pulse; a fetch after release completes normally.
